// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-look-ahead adder:
// the legal operand width range and the look-ahead slice width.
package cla_pkg;
    localparam int CLA_WIDTH_MIN = 8;
    localparam int CLA_WIDTH_MAX = 64;
    localparam int CLA_SLICE_W   = 4;
endpackage

// File: rtl/cla_half_adder_w.sv
// N-bit adder built as a ripple of 4-bit carry-look-ahead slices.
// N must be a multiple of the slice width; the top-level width check guarantees it.
module cla_half_adder_w
    import cla_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NS = N / CLA_SLICE_W;

    logic [NS:0] c;

    assign c[0] = cin;

    for (genvar s = 0; s < NS; s++) begin : g_slice
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;

        assign g = A[s*CLA_SLICE_W +: CLA_SLICE_W] & B[s*CLA_SLICE_W +: CLA_SLICE_W];
        assign p = A[s*CLA_SLICE_W +: CLA_SLICE_W] ^ B[s*CLA_SLICE_W +: CLA_SLICE_W];

        // Every slice carry is a flat sum of products of the slice carry-in.
        assign cc[0] = c[s];
        assign cc[1] = g[0] | (p[0] & cc[0]);
        assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
        assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cc[0]);
        assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & cc[0]);

        assign sum[s*CLA_SLICE_W +: CLA_SLICE_W] = p ^ cc[3:0];
        assign c[s+1] = cc[4];
    end

    assign cout = c[NS];

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined adder: low half in stage 1, upper half plus low carry in stage 2.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int H = WIDTH / 2;

    if ((WIDTH % 8) != 0 || WIDTH < CLA_WIDTH_MIN || WIDTH > CLA_WIDTH_MAX) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 8 in 8..64");
    end

    // Handshake: a beat moves on a port when valid and ready are both high at the
    // rising edge. in_ready never looks at in_valid; valid may not wait for ready.
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    logic [H-1:0] s1_lo_sum;
    logic         s1_lo_c;
    logic [H-1:0] s1_a_hi;
    logic [H-1:0] s1_b_hi;

    logic [WIDTH-1:0] s2_sum;
    logic             s2_cout;

    logic [H-1:0] lo_sum;
    logic         lo_c;
    logic [H-1:0] hi_sum;
    logic         hi_c;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    cla_half_adder_w #(.N(H)) u_lo (
        .A    (a[H-1:0]),
        .B    (b[H-1:0]),
        .cin  (cin),
        .sum  (lo_sum),
        .cout (lo_c)
    );

    cla_half_adder_w #(.N(H)) u_hi (
        .A    (s1_a_hi),
        .B    (s1_b_hi),
        .cin  (s1_lo_c),
        .sum  (hi_sum),
        .cout (hi_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_lo_sum <= '0;
            s1_lo_c   <= 1'b0;
            s1_a_hi   <= '0;
            s1_b_hi   <= '0;
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_cout   <= 1'b0;
        end else begin
            // A bubble clears the valid bit but leaves the data registers untouched.
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_lo_sum <= lo_sum;
                    s1_lo_c   <= lo_c;
                    s1_a_hi   <= a[WIDTH-1:H];
                    s1_b_hi   <= b[WIDTH-1:H];
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sum  <= {hi_sum, s1_lo_sum};
                    s2_cout <= hi_c;
                end
            end
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic s2_ovf;

    // The operand sign bits already travel in the stage-1 upper halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_ovf <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            s2_ovf <= (s1_a_hi[H-1] == s1_b_hi[H-1]) && (hi_sum[H-1] != s1_a_hi[H-1]);
        end
    end

    assign ovf = s2_ovf;
`endif

    assign out_valid = s2_valid;
    assign sum       = s2_sum;
    assign cout      = s2_cout;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32): directed carry, latency,
// stall and reset scenarios plus a randomised run against an arithmetic model.
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_PIPE_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    // Scoreboard entries are {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];
    logic         hold_prev = 1'b0;
    logic [W+1:0] hold_val = '0;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c);
        longint unsigned u;
        longint          s;
        logic            ov;
        u  = longint'(x) + longint'(y) + longint'(c);
        s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov = (s > SMAX) || (s < SMIN);
`ifndef CLA_PIPE_OVF_EN
        ov = 1'b0;
`endif
        return {ov, u[W], u[W-1:0]};
    endfunction

    function automatic logic [W+1:0] obs_word();
`ifdef CLA_PIPE_OVF_EN
        return {ovf, cout, sum};
`else
        return {1'b0, cout, sum};
`endif
    endfunction

    // ---------------- driver / scoreboard step ----------------
    // Inputs are set at the falling edge; transfers are decided just before the
    // next rising edge, and the step returns on the following falling edge.
    task automatic tick();
        logic         in_fire;
        logic         out_fire;
        logic [W+1:0] exp;
        #1;
        in_fire  = in_valid && in_ready && !rst;
        out_fire = out_valid && out_ready && !rst;
        if (hold_prev && !rst) begin
            checks++;
            if (!out_valid || obs_word() !== hold_val) begin
                errors++;
                $display("FAIL hold_stable: got valid=%0b %h expected valid=1 %h",
                         out_valid, obs_word(), hold_val);
            end
        end
        if (out_fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_output: got %h expected no beat", obs_word());
            end else begin
                exp = exp_q.pop_front();
                if (obs_word() !== exp) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", obs_word(), exp);
                end
            end
        end
        if (in_fire) begin
            exp_q.push_back(ref_result(a, b, cin));
            accepted++;
        end
        hold_prev = out_valid && !out_ready && !rst;
        hold_val  = obs_word();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        hold_prev = 1'b0;
    endtask

    task automatic drive_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = $urandom();
        b        = $urandom();
        cin      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got out_valid=%0b in_ready=%0b expected 0 1",
                     out_valid, in_ready);
        end
        checks++;
        if (obs_word() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs_word());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_capture: got out_valid=%0b expected 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_inter_carry();
        out_ready = 1'b1;
        drive_beat(32'h0000FFFF, 32'h00000001, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%0b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h00010000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL inter_carry: got valid=%0b sum=%h cout=%0b expected 1 00010000 0",
                     out_valid, sum, cout);
        end
        tick();
    endtask

    task automatic test_carry_wrap();
        out_ready = 1'b1;
        drive_beat(32'hFFFFFFFF, 32'h00000000, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h00000000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_wrap: got valid=%0b sum=%h cout=%0b expected 1 00000000 1",
                     out_valid, sum, cout);
        end
`ifdef CLA_PIPE_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_wrap_ovf: got %0b expected 0", ovf);
        end
`endif
        tick();
    endtask

`ifdef CLA_PIPE_OVF_EN
    task automatic test_overflow();
        out_ready = 1'b1;
        drive_beat(32'h7FFFFFFF, 32'h00000001, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'h80000000 || ovf !== 1'b1 || cout !== 1'b0) begin
            errors++;
            $display("FAIL overflow: got valid=%0b sum=%h ovf=%0b cout=%0b expected 1 80000000 1 0",
                     out_valid, sum, ovf, cout);
        end
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (out_valid !== ((i >= 2) && (i < 10))) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: got %0b expected %0b", i, out_valid,
                         (i >= 2) && (i < 10));
            end
            in_valid = (i < 8);
            a        = $urandom();
            b        = $urandom();
            cin      = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        int start;
        start     = accepted;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = $urandom();
            b        = $urandom();
            cin      = 1'($urandom_range(0, 1));
            checks++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL stall_in_ready[%0d]: got %0b expected %0b", i, in_ready, i < 2);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (accepted - start != 2 || exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got accepted=%0d pending=%0d valid=%0b expected 2 0 0",
                     accepted - start, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_beat($urandom(), $urandom(), 1'b0);
        drive_beat($urandom(), $urandom(), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill: got valid=%0b in_ready=%0b expected 1 0", out_valid, in_ready);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale[%0d]: got out_valid=%0b expected 0", i, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int start;
        int cycles;
        start  = accepted;
        cycles = 0;
        while ((accepted - start) < 10000 && cycles < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       begin a = '1;        b = $urandom(); end
                1:       begin a = 32'h7FFFFFFF; b = $urandom_range(0, 3); end
                2:       begin a = $urandom(); b = ~a;        end
                default: begin a = $urandom(); b = $urandom(); end
            endcase
            cin = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        checks++;
        if ((accepted - start) < 10000) begin
            errors++;
            $display("FAIL random_timeout: got %0d beats expected 10000", accepted - start);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_dut();
        test_reset();
        test_inter_carry();
        test_carry_wrap();
`ifdef CLA_PIPE_OVF_EN
        test_overflow();
`endif
        test_back_to_back();
        tick();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
